// File: rtl/util_irq2axis.sv
// util_irq2axis: turns level interrupt sources into one-byte MSI vectors on an AXI-Stream port.
// Rising edges are latched as pending bits and served round-robin, with an optional idle holdoff after each delivery.
module util_irq2axis #(
   parameter int NUM_IRQ        = 8,
   parameter int VECTOR_BASE    = 0,
   parameter int HOLDOFF_CYCLES = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   output logic [7:0]         m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic [NUM_IRQ-1:0] pending,
   output logic [1:0]         dbg_state
);

   localparam int          IDX_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam logic [15:0] HOLD_LOAD = 16'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

   if (NUM_IRQ < 1 || NUM_IRQ > 32) begin : g_bad_num_irq
      $error("util_irq2axis: NUM_IRQ must be within 1..32");
   end
   if (VECTOR_BASE < 0 || VECTOR_BASE + NUM_IRQ - 1 > 31) begin : g_bad_vector_base
      $error("util_irq2axis: VECTOR_BASE+NUM_IRQ-1 must be within 0..31");
   end
   if (HOLDOFF_CYCLES < 0 || HOLDOFF_CYCLES > 65535) begin : g_bad_holdoff
      $error("util_irq2axis: HOLDOFF_CYCLES must be within 0..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SEND    = 2'd1,
      S_HOLDOFF = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pending_n;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] elig;
   logic [NUM_IRQ-1:0] clr;
   logic               tvalid_n;
   logic [7:0]         tdata_n;
   logic [IDX_W-1:0]   idx, idx_n;
   logic [IDX_W-1:0]   rr_ptr, rr_n;
   logic [15:0]        hold_cnt, hold_cnt_n;
   logic               found;
   int                 sel_int;
   int                 j;

   assign rise      = irq & ~irq_q;
   assign elig      = pending & ~irq_mask;
   assign dbg_state = state;

   // Round-robin search: first eligible source at or after rr_ptr, wrapping to 0.
   always_comb begin
      found   = 1'b0;
      sel_int = 0;
      j       = 0;
      for (int off = 0; off < NUM_IRQ; off++) begin
         j = int'(rr_ptr) + off;
         if (j >= NUM_IRQ) j = j - NUM_IRQ;
         if (!found && elig[j[IDX_W-1:0]]) begin
            found   = 1'b1;
            sel_int = j;
         end
      end
   end

   // Stream handshake: tvalid rises only from IDLE and then holds, together with
   // tdata, until the edge where tvalid & tready are both high; it is never retracted.
   always_comb begin
      state_n    = state;
      tvalid_n   = m_axis_tvalid;
      tdata_n    = m_axis_tdata;
      idx_n      = idx;
      rr_n       = rr_ptr;
      hold_cnt_n = hold_cnt;
      clr        = '0;
      case (state)
         S_IDLE: begin
            if (found) begin
               tvalid_n = 1'b1;
               tdata_n  = {3'b000, 5'(VECTOR_BASE + sel_int)};
               idx_n    = IDX_W'(sel_int);
               state_n  = S_SEND;
            end
         end
         S_SEND: begin
            if (m_axis_tready) begin
               tvalid_n = 1'b0;
               clr      = NUM_IRQ'(1) << idx;
               if (idx == IDX_W'(NUM_IRQ - 1)) rr_n = '0;
               else                            rr_n = idx + IDX_W'(1);
               if (HOLDOFF_CYCLES > 0) begin
                  hold_cnt_n = HOLD_LOAD;
                  state_n    = S_HOLDOFF;
               end else begin
                  state_n    = S_IDLE;
               end
            end
         end
         S_HOLDOFF: begin
            if (hold_cnt == 16'd0) state_n    = S_IDLE;
            else                   hold_cnt_n = hold_cnt - 16'd1;
         end
         default: state_n = S_IDLE;
      endcase
      // A fresh edge on the source being delivered re-arms it.
      pending_n = (pending & ~clr) | rise;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         irq_q         <= '0;
         pending       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= 8'd0;
         idx           <= '0;
         rr_ptr        <= '0;
         hold_cnt      <= 16'd0;
      end else begin
         state         <= state_n;
         irq_q         <= irq;
         pending       <= pending_n;
         m_axis_tvalid <= tvalid_n;
         m_axis_tdata  <= tdata_n;
         idx           <= idx_n;
         rr_ptr        <= rr_n;
         hold_cnt      <= hold_cnt_n;
      end
   end

endmodule

// File: tb/tb_util_irq2axis.sv
// Bench for util_irq2axis: directed scenarios plus random traffic checked against a
// cycle-level behavioural model of pending bits, arbitration and vector delivery.
module tb_util_irq2axis;

   localparam int N  = 8;
   localparam int VB = 4;

   logic       clk;
   logic       rst_n;
   logic [N-1:0] irq;
   logic [N-1:0] irq_mask;
   logic       tready;
   logic [7:0] tdata0, tdata1;
   logic       tvalid0, tvalid1;
   logic [N-1:0] pend0, pend1;
   logic [1:0] dbg0, dbg1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   util_irq2axis #(.NUM_IRQ(N), .VECTOR_BASE(VB), .HOLDOFF_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .irq(irq), .irq_mask(irq_mask),
      .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
      .pending(pend0), .dbg_state(dbg0)
   );

   util_irq2axis #(.NUM_IRQ(N), .VECTOR_BASE(VB), .HOLDOFF_CYCLES(5)) dut1 (
      .clk(clk), .rst_n(rst_n), .irq(irq), .irq_mask(irq_mask),
      .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
      .pending(pend1), .dbg_state(dbg1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Behavioural model of dut0 (no holdoff): pending set, one vector in flight, rotating priority.
   logic [N-1:0] m_pend, m_prev;
   int           m_fly, m_gap, m_rr;
   logic [7:0]   exp_q[$];
   localparam int M_HOLD = 0;

   always @(posedge clk) begin : model
      logic [N-1:0] old_p, rise_v, clr_v, elig_v;
      int jj;
      if (!rst_n) begin
         m_pend = '0; m_prev = '0; m_fly = -1; m_gap = 0; m_rr = 0;
         exp_q.delete();
      end else begin
         old_p  = m_pend;
         rise_v = irq & ~m_prev;
         m_prev = irq;
         clr_v  = '0;
         if (m_fly >= 0) begin
            if (tready) begin
               clr_v[m_fly] = 1'b1;
               m_rr  = (m_fly + 1) % N;
               m_fly = -1;
               m_gap = M_HOLD;
            end
         end else if (m_gap > 0) begin
            m_gap--;
         end else begin
            elig_v = old_p & ~irq_mask;
            for (int k = 0; k < N; k++) begin
               jj = (m_rr + k) % N;
               if (m_fly < 0 && elig_v[jj]) begin
                  m_fly = jj;
                  exp_q.push_back(8'(VB + jj));
               end
            end
         end
         m_pend = (old_p & ~clr_v) | rise_v;
      end
   end

   // scoreboard and per-cycle comparison against the model
   int         hs0_cyc[$], hs1_cyc[$];
   logic [7:0] hs0_dat[$], hs1_dat[$];

   always @(negedge clk) begin : monitor
      logic [7:0] e;
      check("tvalid", 32'(tvalid0), 32'(m_fly >= 0));
      check("pending", 32'(pend0), 32'(m_pend));
      if (m_fly >= 0) check("tdata", 32'(tdata0), 32'(VB + m_fly));
      if (rst_n && tvalid0 && tready) begin
         hs0_cyc.push_back(cyc);
         hs0_dat.push_back(tdata0);
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_vector", 32'(tdata0), 32'(e));
         end
      end
      if (rst_n && tvalid1 && tready) begin
         hs1_cyc.push_back(cyc);
         hs1_dat.push_back(tdata1);
      end
   end

   initial begin
      rst_n = 1'b0; irq = '0; irq_mask = '0; tready = 1'b0;

      // reset state of both instances
      do_reset();
      check("rst_tvalid0", 32'(tvalid0), 0);
      check("rst_tdata0", 32'(tdata0), 0);
      check("rst_pend0", 32'(pend0), 0);
      check("rst_tvalid1", 32'(tvalid1), 0);
      check("rst_pend1", 32'(pend1), 0);

      // single pulse on source 2: vector 0x06 two edges later
      tready = 1'b1;
      tick();
      irq = 8'h04;
      tick();
      check("a_pend", 32'(pend0), 32'h04);
      check("a_tvalid0", 32'(tvalid0), 0);
      irq = 8'h00;
      tick();
      check("a_tvalid1", 32'(tvalid0), 1);
      check("a_tdata", 32'(tdata0), 32'h06);
      tick();
      check("a_tvalid2", 32'(tvalid0), 0);
      check("a_pend_clr", 32'(pend0), 0);

      // all sources at once: 0x04..0x0B every 2 cycles
      do_reset();
      tready = 1'b1;
      hs0_cyc.delete(); hs0_dat.delete();
      irq = 8'hFF;
      repeat (22) tick();
      check("b_count", 32'(hs0_dat.size()), 8);
      for (int i = 0; i < hs0_dat.size() && i < 8; i++) begin
         check("b_vec", 32'(hs0_dat[i]), 32'(VB + i));
         if (i > 0) check("b_gap", 32'(hs0_cyc[i] - hs0_cyc[i-1]), 2);
      end
      check("b_pend", 32'(pend0), 0);
      irq = 8'h00;
      tick();

      // masked source is held until unmask
      do_reset();
      irq_mask = 8'h01;
      irq = 8'h01;
      tick();
      check("c_pend", 32'(pend0), 32'h01);
      irq = 8'h00;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("c_no_tvalid", 32'(tvalid0), 0);
      end
      check("c_pend_held", 32'(pend0), 32'h01);
      irq_mask = 8'h00;
      hs0_dat.delete(); hs0_cyc.delete();
      tick();
      check("c_tvalid", 32'(tvalid0), 1);
      check("c_tdata", 32'(tdata0), 32'h04);
      tick();
      check("c_done", 32'(tvalid0), 0);
      check("c_hs", 32'(hs0_dat.size()), 1);

      // back-pressure: in-flight vector 3 stays put while irq[5] pulses and mask toggles
      do_reset();
      tready = 1'b0;
      irq = 8'h08;
      tick();
      irq = 8'h00;
      tick();
      check("d_tvalid", 32'(tvalid0), 1);
      check("d_tdata", 32'(tdata0), 32'h07);
      for (int i = 0; i < 10; i++) begin
         irq      = (i % 2 == 0) ? 8'h20 : 8'h00;
         irq_mask = 8'($urandom);
         tick();
         check("d_hold_tvalid", 32'(tvalid0), 1);
         check("d_hold_tdata", 32'(tdata0), 32'h07);
      end
      irq = 8'h00; irq_mask = 8'h00;
      hs0_dat.delete(); hs0_cyc.delete();
      tready = 1'b1;
      repeat (6) tick();
      check("d_count", 32'(hs0_dat.size()), 2);
      if (hs0_dat.size() >= 2) begin
         check("d_first", 32'(hs0_dat[0]), 32'h07);
         check("d_second", 32'(hs0_dat[1]), 32'h09);
      end

      // holdoff of 5 on the second instance: handshakes 7 cycles apart
      do_reset();
      tready = 1'b1;
      hs1_dat.delete(); hs1_cyc.delete();
      irq = 8'h03;
      tick();
      irq = 8'h00;
      repeat (20) tick();
      check("e_count", 32'(hs1_dat.size()), 2);
      if (hs1_dat.size() >= 2) begin
         check("e_first", 32'(hs1_dat[0]), 32'h04);
         check("e_second", 32'(hs1_dat[1]), 32'h05);
         check("e_gap", 32'(hs1_cyc[1] - hs1_cyc[0]), 7);
      end

      // reset during SEND drops everything
      do_reset();
      tready = 1'b0;
      irq = 8'h0C;
      tick();
      irq = 8'h00;
      tick();
      check("f_tvalid", 32'(tvalid0), 1);
      check("f_pend", 32'(pend0), 32'h0C);
      rst_n = 1'b0;
      tick();
      check("f_rst_tvalid", 32'(tvalid0), 0);
      check("f_rst_pend", 32'(pend0), 0);
      rst_n = 1'b1;
      tready = 1'b1;
      hs0_dat.delete(); hs0_cyc.delete();
      repeat (20) tick();
      check("f_no_delivery", 32'(hs0_dat.size()), 0);

      // source high across reset release counts as an edge
      irq = 8'h01;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("g_pend", 32'(pend0), 32'h01);
      irq = 8'h00;
      repeat (4) tick();

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         irq      = irq ^ 8'($urandom & $urandom & $urandom);
         irq_mask = irq_mask ^ 8'($urandom & $urandom & $urandom & $urandom);
         tready   = ($urandom_range(0, 3) != 0);
         rst_n    = ($urandom_range(0, 299) != 0);
         tick();
      end
      rst_n = 1'b1; irq_mask = '0; tready = 1'b1;
      repeat (30) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
